inst_rom_resp: RTL

- Instruction-memory responder serving the CPU fetch port (inst_addr / inst_ena → inst); the memory-side end of the fetch interface.
- Holds a 32-bit word array that a loader stream fills after reset; serves registered single-cycle fetch reads once loading completes.
- Sits beside rvcpu at the SoC/testbench top; replaces the simulation-only instruction ROM.

---
 rtl/inst_rom_resp_if.sv | 29 ++
 rtl/inst_rom_resp.sv | 137 +++++++++++++
 2 files changed

// File: rtl/inst_rom_resp_if.sv
// Fetch/loader bus between the CPU side and the instruction memory responder.
// master = CPU fetch port plus program loader; slave = inst_rom_resp.
interface inst_rom_resp_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic [63:0]         inst_addr;
  logic                inst_ena;
  logic [31:0]         inst;
  logic                inst_valid;
  logic                fetch_err;
  logic                ld_valid;
  logic                ld_ready;
  logic [31:0]         ld_data;
  logic                ld_last;
  logic                ld_restart;
  logic [DEPTH_LOG2:0] ld_count;
  logic                ld_ovf;
  logic                running;

  modport master (
    output inst_addr, inst_ena, ld_valid, ld_data, ld_last, ld_restart,
    input  inst, inst_valid, fetch_err, ld_ready, ld_count, ld_ovf, running
  );

  modport slave (
    input  inst_addr, inst_ena, ld_valid, ld_data, ld_last, ld_restart,
    output inst, inst_valid, fetch_err, ld_ready, ld_count, ld_ovf, running
  );
endinterface

// File: rtl/inst_rom_resp.sv
// Instruction memory responder: loader stream fills the word array, then it serves
// registered single-cycle fetches. Define IROM_LOCK_EN to make the program write-once per reset.
//
// state   | meaning
// ST_LOAD | accepting loader words, fetches answered with inst_valid=0
// ST_RUN  | serving fetches, loader ignored
module inst_rom_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  inst_rom_resp_if.slave bus
);
  localparam int          WORDS     = 1 << DEPTH_LOG2;
  localparam int          CNT_W     = DEPTH_LOG2 + 1;
  localparam logic [63:0] BYTE_SPAN = 64'(WORDS) << 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ld_count_q, ld_count_d;
  logic              ld_ovf_q, ld_ovf_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [31:0]       mem_q [WORDS];

  logic                  ld_ready;
  logic                  running;
  logic                  ld_fire;
  logic                  last_slot;
  logic                  restart_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [64:0]           off_ext;
  logic                  fetch_bad;

`ifdef IROM_LOCK_EN
  // Leaving LOAD is only possible once per reset, so restart is simply never honoured.
  assign restart_en = 1'b0;
`else
  assign restart_en = 1'b1;
`endif

  assign ld_fire   = bus.ld_valid && ld_ready;
  assign last_slot = (ld_count_q == CNT_W'(WORDS - 1));
  assign wr_idx    = ld_count_q[DEPTH_LOG2-1:0];

  // Bit 64 is the borrow, i.e. the address lies below BASE_ADDR.
  assign off_ext   = {1'b0, bus.inst_addr} - {1'b0, BASE_ADDR};
  assign fetch_bad = (bus.inst_addr[1:0] != 2'b00) || off_ext[64] || (off_ext[63:0] >= BYTE_SPAN);
  assign rd_idx    = off_ext[DEPTH_LOG2+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (ld_fire && (bus.ld_last || last_slot)) state_d = ST_RUN;
      ST_RUN:  if (bus.ld_restart && restart_en)          state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    ld_ready = (state_q == ST_LOAD);
    running  = (state_q == ST_RUN);
  end

  always_comb begin
    ld_count_d = ld_count_q;
    ld_ovf_d   = ld_ovf_q;
    mem_we     = 1'b0;
    if (ld_fire) begin
      mem_we     = 1'b1;
      ld_count_d = ld_count_q + CNT_W'(1);
      if (last_slot && !bus.ld_last) ld_ovf_d = 1'b1;
    end
    if (running && bus.ld_restart && restart_en) begin
      ld_count_d = '0;
      ld_ovf_d   = 1'b0;
    end
  end

  always_comb begin
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    fetch_err_d  = 1'b0;
    if (running && bus.inst_ena) begin
      inst_valid_d = 1'b1;
      if (fetch_bad) begin
        inst_d      = NOP;
        fetch_err_d = 1'b1;
      end else begin
        inst_d = mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count_q   <= '0;
      ld_ovf_q     <= 1'b0;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      ld_count_q   <= ld_count_d;
      ld_ovf_q     <= ld_ovf_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Array has no reset; contents survive until overwritten by a later load.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[wr_idx] <= bus.ld_data;
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.running    = running;
  assign bus.ld_count   = ld_count_q;
  assign bus.ld_ovf     = ld_ovf_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.fetch_err  = fetch_err_q;
endmodule
